// File: rtl/keyexp_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | keyexp_pkg : states, rcon constants and xtime for key expansion   |
// | KEYEXP_SBOX_PAR_EN selects the 1-cycle SubWord.  Rev 1.0          |
// +------------------------------------------------------------------+
package keyexp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    SUB  = 2'd2,
    MIX  = 2'd3
  } state_t;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1b;

`ifdef KEYEXP_SBOX_PAR_EN
  localparam int SUB_CYCLES = 1;
`else
  localparam int SUB_CYCLES = 4;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sbox_LUT.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sbox_LUT : combinational AES forward S-box.  Rev 1.0              |
// +------------------------------------------------------------------+
module sbox_LUT (
  input  logic [7:0] addr,
  output logic [7:0] data
);

  localparam logic [0:255][7:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign data = SBOX_TABLE[addr];

endmodule
`default_nettype wire

// File: rtl/key_expansion_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | key_expansion_ctrl : sequential AES-128 key schedule, one round   |
// | key per handshake; KEYEXP_SBOX_PAR_EN gives 4 parallel S-boxes.   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module key_expansion_ctrl
  import keyexp_pkg::*;
#(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_index,
  output logic         done
);

  localparam logic [3:0] c_last_round = 4'(NUM_ROUNDS);
  localparam logic [1:0] c_last_bcnt  = 2'(SUB_CYCLES - 1);

  state_t       r_state;
  state_t       w_state_nxt;
  logic [127:0] r_key;
  logic [31:0]  r_temp;
  logic [7:0]   r_rcon;
  logic [3:0]   r_round;
  logic [1:0]   r_bcnt;
  logic         r_done;

  logic [31:0]  w_w3;
  logic [31:0]  w_rot;
  logic [31:0]  w_temp_nxt;
  logic [31:0]  w_t;
  logic [31:0]  w_w0n;
  logic [31:0]  w_w1n;
  logic [31:0]  w_w2n;
  logic [31:0]  w_w3n;
  logic         w_last;

  assign w_w3   = r_key[31:0];
  assign w_rot  = {w_w3[23:0], w_w3[31:24]};
  assign w_last = (r_round == c_last_round);

`ifdef KEYEXP_SBOX_PAR_EN
  logic [31:0] w_subword;

  generate
    for (genvar i = 0; i < 4; i++) begin : g_sbox
      sbox_LUT u_sbox (
        .addr (w_rot[31-8*i -: 8]),
        .data (w_subword[31-8*i -: 8])
      );
    end
  endgenerate

  assign w_temp_nxt = w_subword;
`else
  logic [31:0] w_rot_sh;
  logic [7:0]  w_sub_byte;

  // Byte bcnt of RotWord is brought to the top; results shift in so byte 0 ends up MSB.
  assign w_rot_sh = w_rot << {r_bcnt, 3'b000};

  sbox_LUT u_sbox (
    .addr (w_rot_sh[31:24]),
    .data (w_sub_byte)
  );

  assign w_temp_nxt = {r_temp[23:0], w_sub_byte};
`endif

  assign w_t   = r_temp ^ {r_rcon, 24'h000000};
  assign w_w0n = r_key[127:96] ^ w_t;
  assign w_w1n = r_key[95:64]  ^ w_w0n;
  assign w_w2n = r_key[63:32]  ^ w_w1n;
  assign w_w3n = w_w3          ^ w_w2n;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    rk_valid    = 1'b0;
    case (r_state)
      IDLE: if (start) w_state_nxt = EMIT;
      EMIT: begin
        busy     = 1'b1;
        rk_valid = 1'b1;
        if (rk_ready) w_state_nxt = w_last ? IDLE : SUB;
      end
      SUB: begin
        busy = 1'b1;
        if (r_bcnt == c_last_bcnt) w_state_nxt = MIX;
      end
      MIX: begin
        busy        = 1'b1;
        w_state_nxt = EMIT;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_key   <= '0;
      r_temp  <= '0;
      r_rcon  <= '0;
      r_round <= '0;
      r_bcnt  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= (r_state == EMIT) && rk_ready && w_last;
      case (r_state)
        IDLE: if (start) begin
          r_key   <= key_in;
          r_round <= '0;
          r_rcon  <= RCON_INIT;
          r_bcnt  <= '0;
        end
        EMIT: r_bcnt <= '0;
        SUB: begin
          r_temp <= w_temp_nxt;
          r_bcnt <= r_bcnt + 2'd1;
        end
        MIX: begin
          r_key   <= {w_w0n, w_w1n, w_w2n, w_w3n};
          r_round <= r_round + 4'd1;
          r_rcon  <= xtime(r_rcon);
        end
        default: ;
      endcase
    end
  end

  assign rk_data  = r_key;
  assign rk_index = r_round;
  assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_key_expansion_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_key_expansion_ctrl : directed, scoreboard-checked bench.       |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_key_expansion_ctrl;

`ifdef KEYEXP_SBOX_PAR_EN
  localparam int STEP = 3;
`else
  localparam int STEP = 6;
`endif
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ALT_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         start1 = 1'b0;
  logic         rk_ready = 1'b1;
  logic [127:0] key_in = '0;
  logic         busy, rk_valid, done;
  logic [127:0] rk_data;
  logic [3:0]   rk_index;
  logic         busy1, rk_valid1, done1;
  logic [127:0] rk_data1;
  logic [3:0]   rk_index1;

  key_expansion_ctrl #(.NUM_ROUNDS(10)) dut (
    .clk(clk), .reset(reset), .start(start), .key_in(key_in),
    .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .rk_data(rk_data), .rk_index(rk_index), .done(done)
  );

  key_expansion_ctrl #(.NUM_ROUNDS(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .key_in(key_in),
    .busy(busy1), .rk_valid(rk_valid1), .rk_ready(rk_ready),
    .rk_data(rk_data1), .rk_index(rk_index1), .done(done1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] data;
  } exp_t;
  exp_t sbq[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference key schedule: S-box derived from GF(2^8) inversion plus affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] ref_sbox(input logic [7:0] a);
    logic [7:0] p = a;
    logic [7:0] r = 8'h01;
    logic [7:0] s;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    s = r;
    for (int n = 1; n < 5; n++) s = s ^ ((r << n) | (r >> (8 - n)));
    return s ^ 8'h63;
  endfunction

  function automatic logic [127:0] next_rk(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w3 = k[31:0];
    logic [31:0] rot = {w3[23:0], w3[31:24]};
    logic [31:0] t, a, b, c, d;
    t = {ref_sbox(rot[31:24]), ref_sbox(rot[23:16]), ref_sbox(rot[15:8]), ref_sbox(rot[7:0])};
    t = t ^ {rc, 24'h0};
    a = k[127:96] ^ t;
    b = k[95:64] ^ a;
    c = k[63:32] ^ b;
    d = w3 ^ c;
    return {a, b, c, d};
  endfunction

  function automatic logic [127:0] key_at(input logic [127:0] key, input int idx);
    logic [127:0] k = key;
    logic [7:0]   rc = 8'h01;
    for (int i = 0; i < idx; i++) begin
      k  = next_rk(k, rc);
      rc = gmul(rc, 8'h02);
    end
    return k;
  endfunction

  task automatic push_sched(input logic [127:0] key);
    for (int i = 0; i <= 10; i++) sbq.push_back({4'(i), key_at(key, i)});
  endtask

  task automatic do_start(input logic [127:0] key, output int c0);
    start  = 1'b1;
    key_in = key;
    push_sched(key);
    @(negedge clk);
    start = 1'b0;
    c0    = cyc;
  endtask

  task automatic wait_key(input int idx, output int at);
    at = -1;
    for (int i = 0; i < 200 && at < 0; i++) begin
      @(negedge clk);
      if (rk_valid && rk_index == 4'(idx)) at = cyc;
    end
    checks++;
    assert (at >= 0) else begin
      errors++;
      $error("FAIL wait_key%0d: observed timeout, expected rk_valid with that index", idx);
    end
  endtask

  task automatic wait_done(output int at);
    at = -1;
    for (int i = 0; i < 200 && at < 0; i++) begin
      @(negedge clk);
      if (done) at = cyc;
    end
    checks++;
    assert (at >= 0) else begin
      errors++;
      $error("FAIL wait_done: observed timeout, expected done pulse");
    end
  endtask

  // Scoreboard consumer: every handshake pops one expected round key.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!reset && rk_valid && rk_ready) begin
      checks++;
      assert (sbq.size() != 0) else begin
        errors++;
        $error("FAIL sb_empty: observed key index %0d, expected no key", rk_index);
      end
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check("sb_index", {124'd0, rk_index}, {124'd0, e.idx});
        check("sb_data", rk_data, e.data);
      end
    end
  end

  initial begin
    int c0, t, td, n;
    logic [127:0] k3;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", rk_valid, 0);
    check("rst_done", done, 0);
    check("rst_data", rk_data, 0);
    check("rst_index", rk_index, 0);
    check("rst1_busy", busy1, 0);
    check("rst1_valid", rk_valid1, 0);
    reset = 1'b0;
    @(negedge clk);

    // FIPS-197 key, always-ready consumer
    do_start(FIPS_KEY, c0);
    check("start_busy", busy, 1);
    check("start_valid", rk_valid, 1);
    check("start_index", rk_index, 0);
    check("start_data", rk_data, FIPS_KEY);
    wait_key(1, t);
    check("spacing_rk1", t - c0, STEP);
    check("fips_rk1", rk_data, 128'ha0fafe1788542cb123a339392a6c7605);
    wait_key(10, t);
    check("fips_rk10", rk_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    wait_done(td);
    check("done_latency", td - c0 + 1, 2 + STEP * 10);
    check("busy_at_done", busy, 0);

    // All-zero key started in the done cycle
    do_start(128'h0, c0);
    check("done_pulse_end", done, 0);
    check("restart_valid", rk_valid, 1);
    check("restart_index", rk_index, 0);
    wait_key(1, t);
    check("zero_rk1", rk_data, 128'h62636363626363636263636362636363);
    wait_key(2, t);
    check("zero_rk2", rk_data, 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa);
    wait_done(td);

    // Backpressure at index 3, ignored start at index 4
    do_start(FIPS_KEY, c0);
    wait_key(3, t);
    rk_ready = 1'b0;
    k3 = key_at(FIPS_KEY, 3);
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", rk_valid, 1);
      check("bp_index", rk_index, 3);
      check("bp_data", rk_data, k3);
    end
    rk_ready = 1'b1;
    wait_key(4, t);
    start  = 1'b1;
    key_in = ALT_KEY;
    @(negedge clk);
    start = 1'b0;
    check("busy_start_ignored", busy, 1);
    wait_done(td);
    check("sb_drained", sbq.size(), 0);

    // Reset in the SUB phase after the index-5 handshake
    do_start(FIPS_KEY, c0);
    wait_key(5, t);
    @(negedge clk);
    reset = 1'b1;
    sbq.delete();
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_valid", rk_valid, 0);
    check("midrst_done", done, 0);
    check("midrst_data", rk_data, 0);
    check("midrst_index", rk_index, 0);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_idle", busy, 0);
    do_start(FIPS_KEY, c0);
    check("post_rst_rk0", rk_data, FIPS_KEY);
    wait_key(1, t);
    check("post_rst_rk1", rk_data, 128'ha0fafe1788542cb123a339392a6c7605);
    wait_done(td);
    check("sb_drained2", sbq.size(), 0);

    // NUM_ROUNDS=1 instance: two keys then done
    key_in = FIPS_KEY;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n  = 0;
    td = -1;
    for (int i = 0; i < 50 && td < 0; i++) begin
      if (rk_valid1 && rk_ready) begin
        check("nr1_index", rk_index1, n);
        check("nr1_data", rk_data1, key_at(FIPS_KEY, n));
        n++;
      end
      if (done1) td = i;
      @(negedge clk);
    end
    check("nr1_done_seen", td >= 0, 1);
    check("nr1_key_count", n, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_expansion_ctrl.md
# key_expansion_ctrl

Sequential AES-128 key-schedule controller that turns a 128-bit cipher key into round keys 0..NUM_ROUNDS, one per handshake. It time-multiplexes a single shared `sbox_LUT` over the four bytes of RotWord(w3), so the SubWord step costs one S-box instead of four. It sits between key load and the round datapath, which consumes round keys in order.

## Interface
- `NUM_ROUNDS`, 10: index of the last round key emitted; legal range 1..10.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin expansion of `key_in`; ignored unless `busy`=0.
- `key_in`  in  128  cipher key; byte 0 = `key_in[127:120]`; w0 = `[127:96]` … w3 = `[31:0]`.
- `busy`  out  1  high from the cycle after an accepted `start` until the final handshake.
- `rk_valid`  out  1  round key available.
- `rk_ready`  in  1  consumer accepts the round key.
- `rk_data`  out  128  current round key, same byte order as `key_in`.
- `rk_index`  out  4  round number of `rk_data` (0..NUM_ROUNDS).
- `done`  out  1  one-cycle pulse after the last round key is accepted.

## Operation
- States: IDLE, EMIT, SUB, MIX.
- IDLE: `start`=1 latches `key_in` into the key register. It also clears the round counter and sets rcon=8'h01, then goes to EMIT.
- EMIT: `rk_valid`=1, `rk_data`=key register, `rk_index`=round.
  - On `rk_valid & rk_ready` with round==NUM_ROUNDS: go to IDLE and pulse `done` the next cycle.
  - Otherwise go to SUB with byte counter 0.
- SUB: each cycle feed byte `bcnt` of RotWord(w3)={w3[23:0],w3[31:24]} to the shared S-box and store the result in temp byte `bcnt`. After `bcnt`=3, go to MIX.
- MIX (one cycle):
  - t = SubWord ^ {rcon,24'h0}
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'
  - round += 1; rcon = xtime(rcon) = (rcon<<1) ^ (rcon[7] ? 8'h1b : 0), truncated to 8 bits
  - go to EMIT.
- rcon sequence for rounds 1..10: 01,02,04,08,10,20,40,80,1b,36.
- `rk_data` and `rk_index` stay stable while `rk_valid`=1 and `rk_ready`=0.
- `start` while `busy`=1 is ignored; the in-progress key is unaffected.
- `rk_ready` outside EMIT is ignored.
- Reset, including mid-operation: state=IDLE; all outputs 0 (`busy`, `rk_valid`, `done`, `rk_data`, `rk_index`); the key register, temp word, rcon and counters are cleared. Reset dominates `start` in the same cycle.

## Timing
- `start` sampled at cycle T: `busy`=1 and `rk_valid`=1 (round 0) at T+1.
- Handshake at cycle H (not the last round): SUB occupies H+1..H+4, MIX H+5, next `rk_valid` at H+6. Inter-key latency is 6 cycles with an always-ready consumer.
- Full run with `rk_ready` tied high: 1 + 6·NUM_ROUNDS cycles from `start` to the last key (61 for NUM_ROUNDS=10).
- Last handshake at cycle L: `busy`=0 and `done`=1 at L+1; `done`=0 at L+2.
- A new `start` is accepted at L+1 at the earliest.
- `rk_valid` is never high in SUB or MIX.

## Configuration
- `KEYEXP_SBOX_PAR_EN` defined:
  - four `sbox_LUT` instances; SUB lasts one cycle and all four bytes are substituted together.
  - inter-key latency 3 cycles (SUB H+1, MIX H+2, valid H+3).
  - full run 1 + 3·NUM_ROUNDS cycles.
- Undefined: single shared S-box with 4-cycle SUB, as specified above.
- Round-key values are identical in both builds.

## Structure
- `keyexp_pkg`:
  - state enum (IDLE/EMIT/SUB/MIX)
  - `RCON_INIT`=8'h01
  - `RCON_POLY`=8'h1b
  - `SUB_CYCLES` (4 or 1, selected by the macro)
  - `xtime` function
- Sub-module: `sbox_LUT` (existing combinational 8-bit S-box). One instance by default, four under `KEYEXP_SBOX_PAR_EN`. The controller is otherwise flat.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, `rk_ready`=1:
  - index 0 = the key; index 1 = a0fafe1788542cb123a339392a6c7605; index 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - `done` exactly 62 cycles after `start`.
- All-zero key: index 1 = 62636363626363636263636362636363.
  - index 2 = 9b9898c9f9fbfbaa9b9898c9f9fbfbaa.
- Backpressure: hold `rk_ready`=0 for 5 cycles at index 3. `rk_data`/`rk_index` stay constant, there is no advance, and the sequence is unchanged afterwards.
- `start` with a different key pulsed at index 4 while busy: ignored; the remaining keys match the original key's schedule.
- `reset` asserted in SUB of round 6: next cycle all outputs are 0 and state is IDLE. A fresh `start` yields the correct index-0 and index-1 keys.
- NUM_ROUNDS=1: exactly two keys are emitted (indices 0 and 1), then `done`. Rerun the first scenario with `KEYEXP_SBOX_PAR_EN`: same keys, 3-cycle spacing.
